m_dmem_resp: RTL and testbench

- Data-memory responder: the memory-side end of a valid/ready load/store request channel.
- Accepts one word-aligned request at a time, applies byte-enabled writes or performs reads against an internal word array, and returns a response after a programmable latency.
- Replaces the zero-latency data memory when the core moves to a handshaked memory interface.
- Also serves as the memory model for the core-side bus master bench.

---
 rtl/m_dmem_resp.sv | 177 +++++++++++++++++
 tb/tb_m_dmem_resp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_dmem_resp.sv
// m_dmem_resp: memory-side responder for a valid/ready load/store channel.
//
// Accepts one word-aligned request at a time. A store writes the enabled
// bytes into the internal word array on the accept edge. A load reads the
// array on the edge that enters RESP. The response appears LATENCY cycles
// after the accept edge and is held until the requester takes it.
//
// Ports:
//   w_clk        clock; all state updates on the rising edge
//   w_rst        synchronous active-high reset
//   w_req_valid  request present
//   w_req_ready  responder can accept a request this cycle
//   w_req_we     1 = store, 0 = load
//   w_req_addr   byte address
//   w_req_wdata  store data
//   w_req_be     byte enables; bit i covers wdata[8i+7:8i]
//   w_rsp_valid  response present
//   w_rsp_ready  requester accepts the response
//   w_rsp_rdata  load data; 0 for stores and erroring requests
//   w_rsp_err    request was misaligned or out of range
module m_dmem_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic        w_req_we,
  input  logic [31:0] w_req_addr,
  input  logic [31:0] w_req_wdata,
  input  logic [3:0]  w_req_be,
  output logic        w_rsp_valid,
  input  logic        w_rsp_ready,
  output logic [31:0] w_rsp_rdata,
  output logic        w_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned WORDS  = 1 << ADDR_W;
  // WAIT counts down from LATENCY-1; with LATENCY=1 it is left on the very
  // next edge, which puts the response up one cycle after the accept.
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  // Misaligned or beyond the array: both flag an error response.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
  endfunction

  logic [31:0]       mem_q [WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept_s;
  logic              req_err_s;
  logic [ADDR_W-1:0] req_idx_s;
  logic              mem_we_s;

  assign req_idx_s = w_req_addr[ADDR_W+1:2];
  assign req_err_s = addr_err(w_req_addr);
  assign accept_s  = (state_q == S_IDLE) && req_ready_q && w_req_valid;
  assign mem_we_s  = accept_s && w_req_we && !req_err_s;

  assign w_req_ready = req_ready_q;
  assign w_rsp_valid = rsp_valid_q;
  assign w_rsp_rdata = rsp_rdata_q;
  assign w_rsp_err   = rsp_err_q;

  // Store commit: enabled bytes are written on the accept edge; the array is
  // never cleared, and a reset on the same edge suppresses the write.
  always_ff @(posedge w_clk) begin
    if (!w_rst && mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (w_req_be[i]) begin
          mem_q[req_idx_s][8*i +: 8] <= w_req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/WAIT/RESP FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d     = S_WAIT;
          cnt_d       = LAT_M1;
          we_d        = w_req_we;
          idx_d       = req_idx_s;
          err_d       = req_err_s;
          req_ready_d = 1'b0;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          // Loads sample the array here, so earlier committed stores are seen.
          rsp_rdata_d = (we_q || err_q) ? 32'd0 : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (w_rsp_ready) begin
          // Ready comes back only after this edge: no same-cycle re-accept.
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = 4'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= {ADDR_W{1'b0}};
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_m_dmem_resp.sv
// tb_m_dmem_resp: directed bench for m_dmem_resp.
// Instance 0 uses LATENCY=2, instance 1 LATENCY=1, instance 2 LATENCY=4.
module tb_m_dmem_resp;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_checks;
  int n_errors;

  m_dmem_resp #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .w_clk(clk), .w_rst(rst),
    .w_req_valid(req_valid[0]), .w_req_ready(req_ready[0]), .w_req_we(req_we[0]),
    .w_req_addr(req_addr[0]), .w_req_wdata(req_wdata[0]), .w_req_be(req_be[0]),
    .w_rsp_valid(rsp_valid[0]), .w_rsp_ready(rsp_ready[0]),
    .w_rsp_rdata(rsp_rdata[0]), .w_rsp_err(rsp_err[0])
  );

  m_dmem_resp #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .w_clk(clk), .w_rst(rst),
    .w_req_valid(req_valid[1]), .w_req_ready(req_ready[1]), .w_req_we(req_we[1]),
    .w_req_addr(req_addr[1]), .w_req_wdata(req_wdata[1]), .w_req_be(req_be[1]),
    .w_rsp_valid(rsp_valid[1]), .w_rsp_ready(rsp_ready[1]),
    .w_rsp_rdata(rsp_rdata[1]), .w_rsp_err(rsp_err[1])
  );

  m_dmem_resp #(.ADDR_W(10), .LATENCY(4)) u_dut_l4 (
    .w_clk(clk), .w_rst(rst),
    .w_req_valid(req_valid[2]), .w_req_ready(req_ready[2]), .w_req_we(req_we[2]),
    .w_req_addr(req_addr[2]), .w_req_wdata(req_wdata[2]), .w_req_be(req_be[2]),
    .w_rsp_valid(rsp_valid[2]), .w_rsp_ready(rsp_ready[2]),
    .w_rsp_rdata(rsp_rdata[2]), .w_rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction on instance k; lat counts edges from accept to
  // the first cycle rsp_valid is seen.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
  endtask

  // Back-to-back loads with valid and rsp_ready held high. Accept at edge N,
  // response visible after N+L, handshake at N+L+1, ready back after that,
  // so the next accept lands on edge N+L+2.
  task automatic back_to_back(input int k, input int lat_cfg);
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          acc_cyc [4];
    int          n_acc;
    int          n_rsp;
    int          cyc;
    logic        rdy;
    for (int i = 0; i < 4; i++) begin
      do_req(k, 1'b1, 32'(i * 4), 32'hC0000000 + 32'(k * 65536 + i), 4'hF, rd, er, lt);
    end
    n_acc = 0;
    n_rsp = 0;
    cyc   = 0;
    req_we[k]    = 1'b0;
    req_addr[k]  = 32'h0;
    req_be[k]    = 4'hF;
    req_valid[k] = 1'b1;
    rsp_ready[k] = 1'b1;
    while ((n_acc < 4 || n_rsp < 4) && cyc < 100) begin
      rdy = req_ready[k] && req_valid[k];
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 4) req_valid[k] = 1'b0;
        else req_addr[k] = 32'(n_acc * 4);
      end
      if (rsp_valid[k]) begin
        check($sformatf("b2b%0d_data%0d", lat_cfg, n_rsp), rsp_rdata[k],
              32'hC0000000 + 32'(k * 65536 + n_rsp));
        n_rsp++;
      end
    end
    rsp_ready[k] = 1'b0;
    check($sformatf("b2b%0d_n_accepts", lat_cfg), 32'(n_acc), 32'd4);
    check($sformatf("b2b%0d_n_responses", lat_cfg), 32'(n_rsp), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < n_acc) begin
        check($sformatf("b2b%0d_spacing%0d", lat_cfg, i),
              32'(acc_cyc[i+1] - acc_cyc[i]), 32'(lat_cfg + 2));
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h000000AA, 4'b0001, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h10,       32'h12345678, 4'b0000, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEAA, 1'b0};
    vecs[6]  = '{1'b0, 32'h12,       32'h0,        4'hF,    32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h1000,     32'h0,        4'hF,    32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h13,       32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h10,       32'h0,        4'hF,    32'hDEADBEAA, 1'b0};
    vecs[10] = '{1'b1, 32'hFFC,      32'h11223344, 4'hF,    32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'b1010, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'hFFC,      32'h0,        4'h0,    32'hCA22F044, 1'b0};
    vecs[13] = '{1'b0, 32'h80000010, 32'h0,        4'hF,    32'h0,        1'b1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'h0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d_req_ready", k), 32'(req_ready[k]), 32'd1);
      check($sformatf("reset%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("reset%0d_rsp_rdata", k), rsp_rdata[k], 32'd0);
      check($sformatf("reset%0d_rsp_err", k), 32'(rsp_err[k]), 32'd0);
    end

    // Table of single transactions on the LATENCY=2 instance.
    for (int i = 0; i < 14; i++) begin
      do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lt);
      check($sformatf("vec%0d_latency", i), 32'(lt), 32'd2);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_req_ready_after", i), 32'(req_ready[0]), 32'd1);
    end

    // Response held with rsp_ready low while a stray store is offered.
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_wdata[0] = 32'h0;
    lt = 0;
    while (!rsp_valid[0] && lt < 40) begin
      @(posedge clk); #1;
      lt++;
    end
    check("hold_latency", 32'(lt), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("hold%0d_rsp_rdata", c), rsp_rdata[0], 32'hDEADBEAA);
      check($sformatf("hold%0d_rsp_err", c), 32'(rsp_err[0]), 32'd0);
      check($sformatf("hold%0d_req_ready", c), 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    check("hold_after_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("hold_after_req_ready", 32'(req_ready[0]), 32'd1);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
    check("hold_stray_store_ignored", rd, 32'hDEADBEAA);

    back_to_back(1, 1);
    back_to_back(2, 4);

    // Reset while the LATENCY=2 instance is in WAIT.
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait_req_ready", 32'(req_ready[0]), 32'd1);
    check("rstwait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rstwait_quiet%0d", c), 32'(rsp_valid[0]), 32'd0);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
    check("rstwait_reload_0x10", rd, 32'hDEADBEAA);
    do_req(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, er, lt);
    check("rstwait_reload_0xffc", rd, 32'hCA22F044);
    check("rstwait_reload_latency", 32'(lt), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
